// File: rtl/acc_dispatcher_mq.sv
// Commit-aware accelerator dispatcher: issued instructions wait in a circular queue
// until the commit stage releases their transaction ID, then go to the accelerator.
module acc_dispatcher_mq #(
  parameter int unsigned Depth          = 4,
  parameter int unsigned NrCommitPorts  = 2,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned TransIdBits    = 3,
  parameter int unsigned XLEN           = 64,
  localparam int unsigned PtrW          = $clog2(Depth),
  localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  input  logic                                 acc_cons_en_i,
  input  logic                                 issue_valid_i,
  output logic                                 issue_ready_o,
  input  logic [31:0]                          issue_insn_i,
  input  logic [XLEN-1:0]                      issue_rs1_i,
  input  logic [XLEN-1:0]                      issue_rs2_i,
  input  logic [TransIdBits-1:0]               issue_trans_id_i,
  input  logic                                 issue_is_load_i,
  input  logic                                 issue_is_store_i,
  input  logic [NrCommitPorts-1:0]             commit_i,
  input  logic [NrCommitPorts*TransIdBits-1:0] commit_trans_id_i,
  input  logic                                 no_st_pending_i,
  output logic                                 acc_req_valid_o,
  input  logic                                 acc_req_ready_i,
  output logic [31:0]                          acc_req_insn_o,
  output logic [XLEN-1:0]                      acc_req_rs1_o,
  output logic [XLEN-1:0]                      acc_req_rs2_o,
  output logic [TransIdBits-1:0]               acc_req_trans_id_o,
  output logic                                 acc_req_store_pending_o,
  input  logic                                 acc_resp_valid_i,
  output logic                                 acc_resp_ready_o,
  input  logic [TransIdBits-1:0]               acc_resp_trans_id_i,
  input  logic [XLEN-1:0]                      acc_resp_result_i,
  input  logic                                 acc_resp_error_i,
  output logic                                 wb_valid_o,
  output logic [TransIdBits-1:0]               wb_trans_id_o,
  output logic [XLEN-1:0]                      wb_result_o,
  output logic                                 wb_ex_valid_o,
  output logic                                 ld_disp_o,
  output logic                                 st_disp_o,
  output logic [CntW-1:0]                      outstanding_o,
  output logic                                 empty_o
);

  typedef struct packed {
    logic [31:0]            insn;
    logic [XLEN-1:0]        rs1;
    logic [XLEN-1:0]        rs2;
    logic [TransIdBits-1:0] trans_id;
    logic                   is_load;
    logic                   is_store;
  } entry_t;

  entry_t                 mem_q [Depth];
  logic [TransIdBits-1:0] ids   [Depth];
  logic [Depth-1:0]       valid_q, valid_d, cmt_q, cmt_d;
  logic [PtrW:0]          head_q, head_d, tail_q, tail_d, kept_cnt;
  logic [PtrW-1:0]        head_idx, tail_idx;
  logic [CntW-1:0]        outst_q, outst_d;
  logic                   full, enq, req_hs;
  entry_t                 head_e, issue_e;

  assign head_idx = head_q[PtrW-1:0];
  assign tail_idx = tail_q[PtrW-1:0];
  // Extra pointer MSB differs only when the tail has lapped the head.
  assign full     = (head_q[PtrW] != tail_q[PtrW]) && (head_idx == tail_idx);
  assign enq      = issue_valid_i && !full;
  assign head_e   = mem_q[head_idx];
  assign issue_e  = '{insn: issue_insn_i, rs1: issue_rs1_i, rs2: issue_rs2_i,
                      trans_id: issue_trans_id_i, is_load: issue_is_load_i,
                      is_store: issue_is_store_i};

  assign issue_ready_o      = !full;
  assign empty_o            = (head_q == tail_q);
  assign acc_req_valid_o    = valid_q[head_idx] && cmt_q[head_idx] &&
                              (outst_q < CntW'(MaxOutstanding));
  assign req_hs             = acc_req_valid_o && acc_req_ready_i;
  assign acc_req_insn_o     = head_e.insn;
  assign acc_req_rs1_o      = head_e.rs1;
  assign acc_req_rs2_o      = head_e.rs2;
  assign acc_req_trans_id_o = head_e.trans_id;
  assign ld_disp_o          = req_hs && head_e.is_load;
  assign st_disp_o          = req_hs && head_e.is_store;
  assign outstanding_o      = outst_q;

  assign acc_req_store_pending_o = !no_st_pending_i && acc_cons_en_i;
  assign acc_resp_ready_o        = 1'b1;
  assign wb_valid_o              = acc_resp_valid_i;
  assign wb_trans_id_o           = acc_resp_trans_id_i;
  assign wb_result_o             = acc_resp_result_i;
  assign wb_ex_valid_o           = acc_resp_error_i;

  // The slot being written this cycle is matched on the incoming ID.
  always_comb begin
    for (int e = 0; e < int'(Depth); e++) begin
      ids[e] = (enq && (PtrW'(e) == tail_idx)) ? issue_trans_id_i : mem_q[e].trans_id;
    end
  end

  always_comb begin
    // NOTE: every variable written here gets a default first, so no latches are inferred.
    valid_d  = valid_q;
    cmt_d    = cmt_q;
    head_d   = head_q + (PtrW+1)'(req_hs);
    tail_d   = tail_q + (PtrW+1)'(enq);
    kept_cnt = '0;
    if (enq) begin
      valid_d[tail_idx] = 1'b1;
      cmt_d[tail_idx]   = 1'b0;
    end
    for (int p = 0; p < int'(NrCommitPorts); p++) begin
      for (int e = 0; e < int'(Depth); e++) begin
        if (commit_i[p] && valid_d[e] && !cmt_d[e] &&
            (ids[e] == commit_trans_id_i[p*TransIdBits +: TransIdBits])) begin
          cmt_d[e] = 1'b1;
        end
      end
    end
    if (req_hs) begin
      valid_d[head_idx] = 1'b0;
      cmt_d[head_idx]   = 1'b0;
    end
    // Committed entries are a contiguous run from the head, so their count locates the new tail.
    if (flush_i) begin
      valid_d = valid_d & cmt_d;
      for (int e = 0; e < int'(Depth); e++) begin
        kept_cnt = kept_cnt + (PtrW+1)'(valid_d[e]);
      end
      tail_d = head_d + kept_cnt;
    end
  end

  always_comb begin
    outst_d = outst_q;
    if (req_hs && !acc_resp_valid_i) begin
      outst_d = outst_q + CntW'(1);
    end else if (!req_hs && acc_resp_valid_i) begin
      outst_d = outst_q - CntW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      cmt_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      outst_q <= '0;
    end else begin
      valid_q <= valid_d;
      cmt_q   <= cmt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      outst_q <= outst_d;
    end
  end

  // NOTE: the payload array has no reset; the valid bits alone qualify its contents.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_q[tail_idx] <= issue_e;
    end
  end

  a_no_lost_issue: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(issue_valid_i && !issue_ready_o));
  a_no_spurious_resp: assert property (@(posedge clk_i) disable iff (!rst_ni)
    acc_resp_valid_i |-> (outst_q != '0));
  a_ld_st_exclusive: assert property (@(posedge clk_i) disable iff (!rst_ni)
    issue_valid_i |-> !(issue_is_load_i && issue_is_store_i));

endmodule

// File: tb/tb_acc_dispatcher_mq.sv
// Directed and randomized bench for acc_dispatcher_mq, checked against a queue-based
// model of the dispatcher's rules.
module tb_acc_dispatcher_mq;
  localparam int DEPTH    = 4;
  localparam int NR_PORTS = 2;
  localparam int MAX_OUT  = 2;
  localparam int TID      = 3;
  localparam int XLEN     = 64;
  localparam int CNTW     = $clog2(MAX_OUT + 1);

  logic                    clk_i = 1'b0;
  logic                    rst_ni;
  logic                    flush_i, acc_cons_en_i, issue_valid_i, issue_ready_o;
  logic [31:0]             issue_insn_i;
  logic [XLEN-1:0]         issue_rs1_i, issue_rs2_i;
  logic [TID-1:0]          issue_trans_id_i;
  logic                    issue_is_load_i, issue_is_store_i;
  logic [NR_PORTS-1:0]     commit_i;
  logic [NR_PORTS*TID-1:0] commit_trans_id_i;
  logic                    no_st_pending_i, acc_req_valid_o, acc_req_ready_i;
  logic [31:0]             acc_req_insn_o;
  logic [XLEN-1:0]         acc_req_rs1_o, acc_req_rs2_o;
  logic [TID-1:0]          acc_req_trans_id_o;
  logic                    acc_req_store_pending_o, acc_resp_valid_i, acc_resp_ready_o;
  logic [TID-1:0]          acc_resp_trans_id_i;
  logic [XLEN-1:0]         acc_resp_result_i;
  logic                    acc_resp_error_i, wb_valid_o;
  logic [TID-1:0]          wb_trans_id_o;
  logic [XLEN-1:0]         wb_result_o;
  logic                    wb_ex_valid_o, ld_disp_o, st_disp_o, empty_o;
  logic [CNTW-1:0]         outstanding_o;

  always #5 clk_i = ~clk_i;

  acc_dispatcher_mq #(
    .Depth(DEPTH), .NrCommitPorts(NR_PORTS), .MaxOutstanding(MAX_OUT),
    .TransIdBits(TID), .XLEN(XLEN)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .acc_cons_en_i(acc_cons_en_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_insn_i(issue_insn_i), .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
    .issue_trans_id_i(issue_trans_id_i), .issue_is_load_i(issue_is_load_i),
    .issue_is_store_i(issue_is_store_i), .commit_i(commit_i),
    .commit_trans_id_i(commit_trans_id_i), .no_st_pending_i(no_st_pending_i),
    .acc_req_valid_o(acc_req_valid_o), .acc_req_ready_i(acc_req_ready_i),
    .acc_req_insn_o(acc_req_insn_o), .acc_req_rs1_o(acc_req_rs1_o),
    .acc_req_rs2_o(acc_req_rs2_o), .acc_req_trans_id_o(acc_req_trans_id_o),
    .acc_req_store_pending_o(acc_req_store_pending_o),
    .acc_resp_valid_i(acc_resp_valid_i), .acc_resp_ready_o(acc_resp_ready_o),
    .acc_resp_trans_id_i(acc_resp_trans_id_i), .acc_resp_result_i(acc_resp_result_i),
    .acc_resp_error_i(acc_resp_error_i), .wb_valid_o(wb_valid_o),
    .wb_trans_id_o(wb_trans_id_o), .wb_result_o(wb_result_o),
    .wb_ex_valid_o(wb_ex_valid_o), .ld_disp_o(ld_disp_o), .st_disp_o(st_disp_o),
    .outstanding_o(outstanding_o), .empty_o(empty_o)
  );

  typedef struct {
    logic [TID-1:0] id;
    logic [31:0]    insn;
    logic [63:0]    rs1;
    logic [63:0]    rs2;
    bit             ld;
    bit             st;
    bit             committed;
  } ref_t;

  ref_t           ref_q[$];
  int             ref_outst = 0;
  int             n_checks  = 0;
  int             n_errors  = 0;
  logic [TID-1:0] nid       = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    flush_i = 0; acc_cons_en_i = 0; issue_valid_i = 0; issue_insn_i = '0;
    issue_rs1_i = '0; issue_rs2_i = '0; issue_trans_id_i = '0;
    issue_is_load_i = 0; issue_is_store_i = 0; commit_i = '0; commit_trans_id_i = '0;
    no_st_pending_i = 1; acc_req_ready_i = 0; acc_resp_valid_i = 0;
    acc_resp_trans_id_i = '0; acc_resp_result_i = '0; acc_resp_error_i = 0;
  endtask

  task automatic drive_issue(input logic [TID-1:0] id, input bit ld, input bit st);
    issue_valid_i = 1; issue_insn_i = $urandom; issue_rs1_i = {$urandom, $urandom};
    issue_rs2_i = {$urandom, $urandom}; issue_trans_id_i = id;
    issue_is_load_i = ld; issue_is_store_i = st;
  endtask

  task automatic drive_commit(input int p, input logic [TID-1:0] id);
    commit_i[p] = 1'b1;
    commit_trans_id_i[p*TID +: TID] = id;
  endtask

  task automatic drive_resp(input logic [TID-1:0] id, input bit err);
    acc_resp_valid_i = 1; acc_resp_trans_id_i = id;
    acc_resp_result_i = {$urandom, $urandom}; acc_resp_error_i = err;
  endtask

  // Expected outputs follow from the model state and the current inputs.
  task automatic compare();
    bit exp_req, exp_hs;
    exp_req = (ref_q.size() > 0) && ref_q[0].committed && (ref_outst < MAX_OUT);
    exp_hs  = exp_req && acc_req_ready_i;
    check("issue_ready", 64'(issue_ready_o), 64'(ref_q.size() < DEPTH));
    check("req_valid", 64'(acc_req_valid_o), 64'(exp_req));
    if (exp_req) begin
      check("req_id", 64'(acc_req_trans_id_o), 64'(ref_q[0].id));
      check("req_insn", 64'(acc_req_insn_o), 64'(ref_q[0].insn));
      check("req_rs1", acc_req_rs1_o, ref_q[0].rs1);
      check("req_rs2", acc_req_rs2_o, ref_q[0].rs2);
    end
    check("ld_disp", 64'(ld_disp_o), 64'(exp_hs && ref_q[0].ld));
    check("st_disp", 64'(st_disp_o), 64'(exp_hs && ref_q[0].st));
    check("outstanding", 64'(outstanding_o), 64'(ref_outst));
    check("empty", 64'(empty_o), 64'(ref_q.size() == 0));
    check("st_pending", 64'(acc_req_store_pending_o), 64'(!no_st_pending_i && acc_cons_en_i));
    check("resp_ready", 64'(acc_resp_ready_o), 64'(1));
    check("wb_valid", 64'(wb_valid_o), 64'(acc_resp_valid_i));
    if (acc_resp_valid_i) begin
      check("wb_id", 64'(wb_trans_id_o), 64'(acc_resp_trans_id_i));
      check("wb_result", wb_result_o, acc_resp_result_i);
      check("wb_ex", 64'(wb_ex_valid_o), 64'(acc_resp_error_i));
    end
  endtask

  task automatic model_step();
    bit   hs;
    ref_t e;
    ref_t keep[$];
    hs = (ref_q.size() > 0) && ref_q[0].committed && (ref_outst < MAX_OUT) && acc_req_ready_i;
    if (issue_valid_i && ref_q.size() < DEPTH) begin
      e.id = issue_trans_id_i; e.insn = issue_insn_i; e.rs1 = issue_rs1_i;
      e.rs2 = issue_rs2_i; e.ld = issue_is_load_i; e.st = issue_is_store_i;
      e.committed = 0;
      ref_q.push_back(e);
    end
    for (int p = 0; p < NR_PORTS; p++) begin
      if (commit_i[p]) begin
        for (int i = 0; i < ref_q.size(); i++) begin
          if (!ref_q[i].committed && ref_q[i].id == commit_trans_id_i[p*TID +: TID]) begin
            ref_q[i].committed = 1;
            break;
          end
        end
      end
    end
    if (hs) void'(ref_q.pop_front());
    if (flush_i) begin
      foreach (ref_q[i]) if (ref_q[i].committed) keep.push_back(ref_q[i]);
      ref_q = keep;
    end
    if (hs) ref_outst++;
    if (acc_resp_valid_i) ref_outst--;
  endtask

  task automatic settle();
    #1;
    compare();
  endtask

  task automatic advance();
    model_step();
    @(posedge clk_i);
    @(negedge clk_i);
    idle();
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  // Random legal traffic; commits always go to the oldest uncommitted IDs in order.
  task automatic auto_cycle(input int issue_pct, input int flush_pct, input bit eager);
    logic [TID-1:0] cand[$];
    int k, r;
    foreach (ref_q[i]) if (!ref_q[i].committed) cand.push_back(ref_q[i].id);
    if (ref_q.size() < DEPTH && $urandom_range(0, 99) < issue_pct) begin
      r = $urandom_range(0, 2);
      drive_issue(nid, r == 1, r == 2);
      cand.push_back(nid);
      nid++;
    end
    k = eager ? NR_PORTS : $urandom_range(0, NR_PORTS);
    for (int p = 0; p < k && p < cand.size(); p++) drive_commit(p, cand[p]);
    acc_req_ready_i = eager || ($urandom_range(0, 3) != 0);
    if (ref_outst > 0 && (eager || $urandom_range(0, 2) == 0))
      drive_resp(TID'($urandom), 1'($urandom));
    flush_i = ($urandom_range(0, 99) < flush_pct);
    no_st_pending_i = 1'($urandom);
    acc_cons_en_i = 1'($urandom);
    cycle();
  endtask

  task automatic drain();
    int guard = 0;
    while ((ref_q.size() != 0 || ref_outst != 0) && guard < 64) begin
      auto_cycle(0, 0, 1);
      guard++;
    end
    check("drain_empty", 64'(empty_o), 64'(1));
    check("drain_outst", 64'(outstanding_o), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_ni = 1;
    #1 rst_ni = 0;
    #2;
    check("rst_issue_ready", 64'(issue_ready_o), 64'(1));
    check("rst_req_valid", 64'(acc_req_valid_o), 64'(0));
    check("rst_empty", 64'(empty_o), 64'(1));
    check("rst_outst", 64'(outstanding_o), 64'(0));
    check("rst_ld", 64'(ld_disp_o), 64'(0));
    check("rst_st", 64'(st_disp_o), 64'(0));
    @(negedge clk_i);
    rst_ni = 1;

    // Requests wait for their commit and leave one cycle after it.
    drive_issue(1, 1, 0); cycle();
    drive_issue(2, 0, 1); cycle();
    drive_commit(0, 1); acc_req_ready_i = 1; settle();
    check("t1_not_yet", 64'(acc_req_valid_o), 64'(0)); advance();
    acc_req_ready_i = 1; settle();
    check("t1_req_valid", 64'(acc_req_valid_o), 64'(1));
    check("t1_req_id", 64'(acc_req_trans_id_o), 64'(1));
    check("t1_ld_pulse", 64'(ld_disp_o), 64'(1)); advance();
    acc_req_ready_i = 1; drive_resp(1, 0); settle();
    check("t1_id2_held", 64'(acc_req_valid_o), 64'(0)); advance();
    drive_commit(0, 2); cycle();
    acc_req_ready_i = 1; settle();
    check("t6_st_pulse_on", 64'(st_disp_o), 64'(1));
    check("t1_req_id2", 64'(acc_req_trans_id_o), 64'(2)); advance();
    drive_resp(2, 0); settle();
    check("t6_st_pulse_off", 64'(st_disp_o), 64'(0)); advance();

    // Dual-port commit, back-to-back issue, then the outstanding limit.
    drive_issue(3, 0, 0); cycle();
    drive_issue(4, 0, 0); cycle();
    drive_commit(0, 3); drive_commit(1, 4); acc_req_ready_i = 1; cycle();
    acc_req_ready_i = 1; settle();
    check("t2_first", 64'(acc_req_trans_id_o), 64'(3));
    check("t2_out0", 64'(outstanding_o), 64'(0)); advance();
    acc_req_ready_i = 1; settle();
    check("t2_second_valid", 64'(acc_req_valid_o), 64'(1));
    check("t2_second", 64'(acc_req_trans_id_o), 64'(4));
    check("t2_out1", 64'(outstanding_o), 64'(1)); advance();
    drive_issue(5, 0, 0); drive_commit(0, 5); acc_req_ready_i = 1; settle();
    check("t2_out2", 64'(outstanding_o), 64'(2)); advance();
    acc_req_ready_i = 1; settle();
    check("t5_stall", 64'(acc_req_valid_o), 64'(0)); advance();
    acc_req_ready_i = 1; drive_resp(3, 0); settle();
    check("t5_stall_resp", 64'(acc_req_valid_o), 64'(0)); advance();
    acc_req_ready_i = 1; drive_issue(6, 0, 0); drive_commit(0, 6); settle();
    check("t5_release", 64'(acc_req_valid_o), 64'(1));
    check("t5_release_id", 64'(acc_req_trans_id_o), 64'(5)); advance();
    drive_resp(6, 1); settle();
    check("t6_wb_valid", 64'(wb_valid_o), 64'(1));
    check("t6_wb_ex", 64'(wb_ex_valid_o), 64'(1));
    check("t6_wb_id", 64'(wb_trans_id_o), 64'(6));
    check("t5_out_full", 64'(outstanding_o), 64'(2)); advance();
    acc_req_ready_i = 1; drive_resp(4, 0); settle();
    check("t5_sim_valid", 64'(acc_req_valid_o), 64'(1)); advance();
    drive_resp(5, 0); settle();
    check("t5_sim_keep", 64'(outstanding_o), 64'(1)); advance();

    // Full queue, pop-then-ready, pointer wrap.
    for (int i = 0; i < DEPTH; i++) begin
      drive_issue(TID'(i), 0, 0); cycle();
    end
    drive_commit(0, 0); settle();
    check("t3_full", 64'(issue_ready_o), 64'(0));
    check("t3_not_empty", 64'(empty_o), 64'(0)); advance();
    acc_req_ready_i = 1; settle();
    check("t3_pop", 64'(acc_req_valid_o), 64'(1));
    check("t3_still_full", 64'(issue_ready_o), 64'(0)); advance();
    settle();
    check("t3_ready_again", 64'(issue_ready_o), 64'(1)); advance();
    nid = 4;
    for (int i = 0; i < 12; i++) auto_cycle(100, 0, 1);
    drain();

    // Flush keeps the committed head and drops the rest, including a same-cycle enqueue.
    drive_issue(5, 0, 0); cycle();
    drive_issue(6, 0, 0); drive_commit(0, 5); cycle();
    drive_issue(7, 0, 0); flush_i = 1; cycle();
    acc_req_ready_i = 1; settle();
    check("t4_kept", 64'(acc_req_valid_o), 64'(1));
    check("t4_id", 64'(acc_req_trans_id_o), 64'(5));
    check("t4_not_empty", 64'(empty_o), 64'(0)); advance();
    settle();
    check("t4_empty", 64'(empty_o), 64'(1)); advance();

    nid = 0;
    for (int i = 0; i < 3000; i++) auto_cycle(60, 6, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
